// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the on-chip UART bridge: default divisor, the
// 2-bit FSM state encoding used by both the TX and RX machines, and the
// serial-port addresses that the memory controller decodes.
package uart_bridge_pkg;

    // Clocks per bit for a 50 MHz clock at 115200 baud.
    localparam int UART_DIVISOR = 434;

    // Data register and status word, shared with the memory controller.
    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    // One encoding serves both directions of the 8N1 frame.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_bridge_if.sv
// Bus-side and line-side signals of the UART bridge.
//
// Handshake: rdn and wrn are active-low strobes from the memory controller.
// A write is taken on the falling edge of wrn (first low cycle) and only
// when tbre is high; a write while tbre is low is dropped. A read drives
// data_o onto the bus while data_oe is high (rdn delayed one cycle) and is
// consumed on the rising edge of rdn, which clears data_ready.
interface uart_bridge_if;
    logic       rdn;
    logic       wrn;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_oe;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    logic       uart_txd;
    logic       uart_rxd;

    // UART side: receives strobes and the serial input, drives status.
    modport slave (
        input  rdn, wrn, data_i, uart_rxd,
        output data_o, data_oe, data_ready, tbre, tsre, uart_txd
    );

    // Controller / line side.
    modport master (
        output rdn, wrn, data_i, uart_rxd,
        input  data_o, data_oe, data_ready, tbre, tsre, uart_txd
    );
endinterface

// File: rtl/uart_bridge_rx.sv
// Receive half of the UART bridge: two-flop synchronizer on the serial
// input, 8N1 receive FSM and the one-byte receive buffer. o_rx_done and
// o_rx_ferr are single-cycle strobes decoded from registered state, valid
// in the cycle whose closing edge loads (or discards) the byte.
module uart_bridge_rx
    import uart_bridge_pkg::*;
#(
    parameter int DIVISOR = UART_DIVISOR
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rxd,
    output logic [7:0]  o_data,
    output logic        o_rx_done,
    output logic        o_rx_ferr,
    output uart_state_e o_state
);
    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_line_q;
    uart_state_e r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_buf;

    uart_state_e w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  w_shift_nxt;
    logic        w_done;
    logic        w_ferr;
    logic        w_fall;

    // Synchronize the asynchronous line and keep one delayed copy for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_q <= 1'b1;
        end else begin
            r_sync1  <= i_rxd;
            r_sync2  <= r_sync1;
            r_line_q <= r_sync2;
        end
    end

    assign w_fall = r_line_q & ~r_sync2;

    // RX FSM state register, bit/baud counters and shifter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // RX next-state: half-bit check of the start bit, then one sample per bit time.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = HALF_M1;
                end
            end
            ST_START: begin
                if (r_cnt == '0) begin
                    if (r_sync2) begin
                        // Line went back high before mid-start: a glitch.
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = DIV_M1;
                        w_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt   = DIV_M1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    if (r_sync2) begin
                        w_done = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Receive buffer: only a byte with a valid stop bit replaces it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf <= '0;
        end else if (w_done) begin
            r_buf <= r_shift;
        end
    end

    assign o_data    = r_buf;
    assign o_rx_done = w_done;
    assign o_rx_ferr = w_ferr;
    assign o_state   = r_state;

endmodule

// File: rtl/uart_bridge.sv
// On-chip UART answering the rdn/wrn strobe handshake of the memory
// controller. Owns strobe edge detection, the transmit holding register,
// the TX serializer and the tbre/tsre/data_ready/data_oe flags; the
// receive path lives in uart_bridge_rx.
module uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 115200,
    parameter int DIVISOR = CLK_HZ / BAUD
) (
    input  logic         clk_50MHz,
    input  logic         rst,
    uart_bridge_if.slave bus,
    output uart_state_e  o_dbg_tx_state,
    output uart_state_e  o_dbg_rx_state,
    output logic         o_dbg_rx_ferr
);
    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          r_wrn_q;
    logic          r_rdn_q;
    logic          r_tbre;
    logic          r_tsre;
    logic [7:0]    r_hold;
    uart_state_e   r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_txd;
    logic          r_data_ready;
    logic          r_data_oe;

    logic          w_wr_evt;
    logic          w_rd_end;
    logic          w_tx_reload;
    logic          w_tbre_nxt;
    logic [7:0]    w_hold_nxt;
    uart_state_e   w_tx_state_nxt;
    logic [CW-1:0] w_tx_cnt_nxt;
    logic [2:0]    w_tx_bit_nxt;
    logic [7:0]    w_tx_shift_nxt;
    logic          w_txd_nxt;
    logic          w_tsre_nxt;
    logic [7:0]    w_rx_data;
    logic          w_rx_done;
    logic          w_rx_ferr;
    uart_state_e   w_rx_state;

    // Register both strobes so their edges can be seen without glitches.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_wrn_q <= 1'b1;
            r_rdn_q <= 1'b1;
        end else begin
            r_wrn_q <= bus.wrn;
            r_rdn_q <= bus.rdn;
        end
    end

    assign w_wr_evt = r_wrn_q & ~bus.wrn;
    assign w_rd_end = ~r_rdn_q & bus.rdn;

    // Holding register and tbre: a reload empties it, an accepted write fills it.
    always_comb begin
        w_tbre_nxt = r_tbre;
        w_hold_nxt = r_hold;
        if (w_tx_reload) begin
            w_tbre_nxt = 1'b1;
        end else if (w_wr_evt && r_tbre) begin
            w_tbre_nxt = 1'b0;
            w_hold_nxt = bus.data_i;
        end
    end

    // TX next-state: start, 8 data bits LSB first, stop; reload straight
    // from STOP when another byte is already waiting.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_txd_nxt      = r_txd;
        w_tsre_nxt     = r_tsre;
        w_tx_reload    = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                if (!r_tbre) begin
                    w_tx_reload = 1'b1;
                end
            end
            ST_START: begin
                if (r_tx_cnt == '0) begin
                    w_tx_state_nxt = ST_DATA;
                    w_tx_cnt_nxt   = DIV_M1;
                    w_tx_bit_nxt   = 3'd0;
                    w_txd_nxt      = r_tx_shift[0];
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_nxt = DIV_M1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = ST_STOP;
                        w_txd_nxt      = 1'b1;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_txd_nxt      = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == '0) begin
                    if (!r_tbre) begin
                        w_tx_reload = 1'b1;
                    end else begin
                        w_tx_state_nxt = ST_IDLE;
                        w_tsre_nxt     = 1'b1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - CNT_ONE;
                end
            end
            default: w_tx_state_nxt = ST_IDLE;
        endcase
        if (w_tx_reload) begin
            w_tx_state_nxt = ST_START;
            w_tx_cnt_nxt   = DIV_M1;
            w_tx_shift_nxt = r_hold;
            w_txd_nxt      = 1'b0;
            w_tsre_nxt     = 1'b0;
        end
    end

    // TX FSM state register with its datapath, holding register and flags.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tsre     <= 1'b1;
            r_tbre     <= 1'b1;
            r_hold     <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_txd      <= w_txd_nxt;
            r_tsre     <= w_tsre_nxt;
            r_tbre     <= w_tbre_nxt;
            r_hold     <= w_hold_nxt;
        end
    end

    uart_bridge_rx #(
        .DIVISOR (DIVISOR)
    ) u_rx (
        .i_clk     (clk_50MHz),
        .i_rst     (rst),
        .i_rxd     (bus.uart_rxd),
        .o_data    (w_rx_data),
        .o_rx_done (w_rx_done),
        .o_rx_ferr (w_rx_ferr),
        .o_state   (w_rx_state)
    );

    // Read-side flags: a completing byte beats a simultaneous read end.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_data_ready <= 1'b0;
            r_data_oe    <= 1'b0;
        end else begin
            r_data_oe <= ~bus.rdn;
            if (w_rx_done) begin
                r_data_ready <= 1'b1;
            end else if (w_rd_end) begin
                r_data_ready <= 1'b0;
            end
        end
    end

    assign bus.data_o     = w_rx_data;
    assign bus.data_oe    = r_data_oe;
    assign bus.data_ready = r_data_ready;
    assign bus.tbre       = r_tbre;
    assign bus.tsre       = r_tsre;
    assign bus.uart_txd   = r_txd;

    assign o_dbg_tx_state = r_tx_state;
    assign o_dbg_rx_state = w_rx_state;
    assign o_dbg_rx_ferr  = w_rx_ferr;

endmodule

// File: tb/tb_uart_bridge.sv
// Directed bench for uart_bridge at DIVISOR=16: table-driven TX and RX
// frames plus hand-written sequences for back-to-back TX, read timing,
// glitch rejection, the read/complete race and reset mid-frame.
module tb_uart_bridge;
    import uart_bridge_pkg::*;

    localparam int DIV = 16;

    typedef struct {
        logic [7:0] din;
        logic [9:0] line;   // line[k] = expected txd in bit slot k
    } tx_vec_t;

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       pre_read;
        logic       chk_lat;
        logic       exp_rdy;
        logic [7:0] exp_do;
    } rx_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_state_e dbg_tx;
    uart_state_e dbg_rx;
    logic        dbg_ferr;

    int n_cmp = 0;
    int n_bad = 0;

    tx_vec_t tx_tab[4];
    rx_vec_t rx_tab[4];

    uart_bridge_if u_if ();

    uart_bridge #(
        .DIVISOR (DIV)
    ) dut (
        .clk_50MHz      (clk),
        .rst            (rst),
        .bus            (u_if.slave),
        .o_dbg_tx_state (dbg_tx),
        .o_dbg_rx_state (dbg_rx),
        .o_dbg_rx_ferr  (dbg_ferr)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // rdn low for 3 cycles, then a short settle.
    task automatic read_pulse();
        u_if.rdn = 1'b0;
        repeat (3) tick();
        u_if.rdn = 1'b1;
        repeat (2) tick();
    endtask

    // Drive one 8N1 frame on uart_rxd starting right after the current edge
    // (t=0); optionally hold rdn low over cycles rd_lo..rd_hi.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int rd_lo, input int rd_hi,
                              output logic rdy154, output logic rdy155);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        rdy154 = 1'bx;
        rdy155 = 1'bx;
        u_if.uart_rxd = fr[0];
        for (int t = 1; t <= 160; t++) begin
            tick();
            u_if.uart_rxd = (t < 160) ? fr[t / 16] : 1'b1;
            u_if.rdn      = (t >= rd_lo && t <= rd_hi) ? 1'b0 : 1'b1;
            if (t == 154) rdy154 = u_if.data_ready;
            if (t == 155) rdy155 = u_if.data_ready;
        end
        repeat (20) tick();
    endtask

    initial begin
        logic r154, r155;
        logic [19:0] b2b_line;
        int changes;

        u_if.rdn      = 1'b1;
        u_if.wrn      = 1'b1;
        u_if.data_i   = 8'h00;
        u_if.uart_rxd = 1'b1;

        tx_tab[0] = '{din: 8'hA5, line: 10'b1_10100101_0};
        tx_tab[1] = '{din: 8'h00, line: 10'b1_00000000_0};
        tx_tab[2] = '{din: 8'hFF, line: 10'b1_11111111_0};
        tx_tab[3] = '{din: 8'h3C, line: 10'b1_00111100_0};

        rx_tab[0] = '{din: 8'h3C, stop: 1'b1, pre_read: 1'b0, chk_lat: 1'b1, exp_rdy: 1'b1, exp_do: 8'h3C};
        rx_tab[1] = '{din: 8'h5A, stop: 1'b0, pre_read: 1'b1, chk_lat: 1'b0, exp_rdy: 1'b0, exp_do: 8'h3C};
        rx_tab[2] = '{din: 8'h11, stop: 1'b1, pre_read: 1'b0, chk_lat: 1'b0, exp_rdy: 1'b1, exp_do: 8'h11};
        rx_tab[3] = '{din: 8'h22, stop: 1'b1, pre_read: 1'b0, chk_lat: 1'b0, exp_rdy: 1'b1, exp_do: 8'h22};

        // Reset and idle
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_txd", 32'(u_if.uart_txd), 32'd1);
        check("rst_tbre", 32'(u_if.tbre), 32'd1);
        check("rst_tsre", 32'(u_if.tsre), 32'd1);
        check("rst_rdy", 32'(u_if.data_ready), 32'd0);
        check("rst_oe", 32'(u_if.data_oe), 32'd0);
        check("rst_do", 32'(u_if.data_o), 32'h00);
        check("rst_txst", 32'(dbg_tx), 32'(ST_IDLE));
        changes = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (u_if.uart_txd !== 1'b1 || u_if.tbre !== 1'b1 || u_if.tsre !== 1'b1 ||
                u_if.data_ready !== 1'b0 || u_if.data_oe !== 1'b0) changes++;
        end
        check("idle_changes", 32'(changes), 32'd0);

        // Single TX frames from the table
        for (int v = 0; v < 4; v++) begin
            u_if.data_i = tx_tab[v].din;
            u_if.wrn    = 1'b0;
            tick();
            check("tx_tbre_drop", 32'(u_if.tbre), 32'd0);
            tick();
            u_if.wrn = 1'b1;
            check("tx_tbre_back", 32'(u_if.tbre), 32'd1);
            check("tx_tsre_busy", 32'(u_if.tsre), 32'd0);
            check("tx_start_edge", 32'(u_if.uart_txd), 32'd0);
            for (int c = 1; c <= 165; c++) begin
                tick();
                if (c % 16 == 8 && c < 160)
                    check($sformatf("tx%0d_slot%0d", v, c / 16), 32'(u_if.uart_txd), 32'(tx_tab[v].line[c / 16]));
                if (c == 159) check("tx_tsre_159", 32'(u_if.tsre), 32'd0);
                if (c == 160) check("tx_tsre_160", 32'(u_if.tsre), 32'd1);
            end
        end

        // Back-to-back TX: 0x55, then 0x0F mid-frame, then 0xAA dropped
        b2b_line = {10'b1_00001111_0, 10'b1_01010101_0};
        u_if.data_i = 8'h55;
        u_if.wrn    = 1'b0;
        tick();
        tick();
        u_if.wrn = 1'b1;
        for (int c = 1; c <= 330; c++) begin
            tick();
            if (c == 20) begin u_if.data_i = 8'h0F; u_if.wrn = 1'b0; end
            else if (c == 40) begin u_if.data_i = 8'hAA; u_if.wrn = 1'b0; end
            else u_if.wrn = 1'b1;
            if (c == 21) check("b2b_tbre_2nd", 32'(u_if.tbre), 32'd0);
            if (c == 41) check("b2b_tbre_3rd", 32'(u_if.tbre), 32'd0);
            if (c % 16 == 8 && c < 320)
                check($sformatf("b2b_slot%0d", c / 16), 32'(u_if.uart_txd), 32'(b2b_line[c / 16]));
            if (c == 160) begin
                check("b2b_gap_tsre", 32'(u_if.tsre), 32'd0);
                check("b2b_reload_tbre", 32'(u_if.tbre), 32'd1);
                check("b2b_reload_txd", 32'(u_if.uart_txd), 32'd0);
            end
            if (c == 319) check("b2b_tsre_319", 32'(u_if.tsre), 32'd0);
            if (c == 320) check("b2b_tsre_320", 32'(u_if.tsre), 32'd1);
            if (c == 330) check("b2b_no_third", 32'(dbg_tx), 32'(ST_IDLE));
        end

        // RX frames from the table
        for (int v = 0; v < 4; v++) begin
            if (rx_tab[v].pre_read) read_pulse();
            send_frame(rx_tab[v].din, rx_tab[v].stop, -1, -1, r154, r155);
            if (rx_tab[v].chk_lat) begin
                check("rx_lat_154", 32'(r154), 32'd0);
                check("rx_lat_155", 32'(r155), 32'd1);
            end
            check($sformatf("rx%0d_rdy", v), 32'(u_if.data_ready), 32'(rx_tab[v].exp_rdy));
            check($sformatf("rx%0d_do", v), 32'(u_if.data_o), 32'(rx_tab[v].exp_do));
        end

        // Read strobe timing: data_oe follows rdn by one cycle
        u_if.rdn = 1'b0;
        check("rd_oe_0", 32'(u_if.data_oe), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 3) u_if.rdn = 1'b1;
            check($sformatf("rd_oe_%0d", i), 32'(u_if.data_oe), (i <= 3) ? 32'd1 : 32'd0);
            check($sformatf("rd_rdy_%0d", i), 32'(u_if.data_ready), (i <= 3) ? 32'd1 : 32'd0);
        end
        check("rd_do", 32'(u_if.data_o), 32'h22);

        // 4-cycle low glitch must not produce a byte
        u_if.uart_rxd = 1'b0;
        repeat (4) tick();
        u_if.uart_rxd = 1'b1;
        repeat (200) tick();
        check("glitch_rdy", 32'(u_if.data_ready), 32'd0);
        check("glitch_state", 32'(dbg_rx), 32'(ST_IDLE));
        check("glitch_do", 32'(u_if.data_o), 32'h22);

        // Read end in the same cycle as byte completion
        send_frame(8'h96, 1'b1, 150, 153, r154, r155);
        check("race_rdy_155", 32'(r155), 32'd1);
        check("race_rdy", 32'(u_if.data_ready), 32'd1);
        check("race_do", 32'(u_if.data_o), 32'h96);

        // Reset during data bit 4 of a TX frame (0xC3: bit 4 = 0)
        u_if.data_i = 8'hC3;
        u_if.wrn    = 1'b0;
        tick();
        tick();
        u_if.wrn = 1'b1;
        repeat (88) tick();
        check("rst_mid_bit4", 32'(u_if.uart_txd), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_txd", 32'(u_if.uart_txd), 32'd1);
        check("rst_mid_tsre", 32'(u_if.tsre), 32'd1);
        check("rst_mid_tbre", 32'(u_if.tbre), 32'd1);
        changes = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (u_if.uart_txd !== 1'b1 || u_if.tsre !== 1'b1) changes++;
        end
        check("rst_mid_quiet", 32'(changes), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
